// File: rtl/dp_selmux_rr.sv
// Registered CH-way channel selector: forced / fixed-priority / round-robin grant
// feeding one output register with a valid/ready handshake.

module dp_selmux_rr_ch #(
    parameter int N = 32
) (
    input  logic         valid,
    input  logic         at_or_above_ptr,
    input  logic         grant,
    input  logic [N-1:0] data,
    output logic [N-1:0] data_m,
    output logic         rr_req
);
    assign data_m = grant ? data : '0;
    assign rr_req = valid & at_or_above_ptr;
endmodule

module dp_selmux_rr #(
    parameter int N     = 32,
    parameter int CH    = 4,
    parameter int SW    = 2,
    parameter     GROUP = "dpath1"
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [CH*N-1:0] IN_DATA,
    input  logic [CH-1:0]   IN_VALID,
    output logic [CH-1:0]   IN_READY,
    input  logic [1:0]      MODE,
    input  logic [SW-1:0]   SEL,
    output logic [N-1:0]    Y,
    output logic [SW-1:0]   Y_CH,
    output logic            Y_VALID,
    input  logic            Y_READY
);
    typedef struct packed {
        logic [N-1:0]  data;
        logic [SW-1:0] ch;
    } resp_t;

    logic [CH-1:0][N-1:0] din;
    logic [CH-1:0][N-1:0] din_m;
    logic [CH-1:0]        lo_mask;
    logic [CH-1:0]        rr_req;
    logic [CH-1:0]        pri_req;
    logic [CH-1:0]        grant;
    logic [SW-1:0]        ptr;
    logic [SW-1:0]        gidx;
    logic [N-1:0]         gdata;
    logic                 any_gnt;
    logic                 found;
    logic                 load;
    logic                 xfer;
    resp_t                y_q;
    logic                 y_vld;

    assign din = IN_DATA;
    // Channels below the pointer are masked out for the first round-robin pass.
    assign lo_mask = (CH'(1) << ptr) - CH'(1);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        dp_selmux_rr_ch #(.N(N)) u_ch (
            .valid          (IN_VALID[i]),
            .at_or_above_ptr(~lo_mask[i]),
            .grant          (grant[i]),
            .data           (din[i]),
            .data_m         (din_m[i]),
            .rr_req         (rr_req[i])
        );
    end

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        pri_req = IN_VALID;
        // Round-robin wraps to the lowest valid channel when nothing is at/above ptr.
        if (MODE == 2'b10 && |rr_req) pri_req = rr_req;
        if (MODE == 2'b00) begin
            for (int i = 0; i < CH; i++)
                if (SEL == SW'(i)) grant[i] = IN_VALID[i];
        end else begin
            for (int i = 0; i < CH; i++)
                if (pri_req[i] && !found) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
        end
    end

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant[i]) gidx = gidx | SW'(i);
            gdata = gdata | din_m[i];
        end
    end

    assign any_gnt  = |grant;
    assign load     = ~y_vld | Y_READY;
    assign xfer     = load & any_gnt;
    assign IN_READY = grant & {CH{load & RST_N}};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_q   <= '0;
            y_vld <= 1'b0;
            ptr   <= '0;
        end else if (load) begin
            y_vld <= any_gnt;
            if (any_gnt) begin
                y_q.data <= gdata;
                y_q.ch   <= gidx;
                if (MODE == 2'b10)
                    ptr <= (gidx == SW'(CH - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    assign Y       = y_q.data;
    assign Y_CH    = y_q.ch;
    assign Y_VALID = y_vld;
endmodule

// File: tb/tb_dp_selmux_rr.sv
// Directed bench for dp_selmux_rr: a 4-channel instance for the main checks and
// a 3-channel instance for the out-of-range select and pointer wrap.

module tb_dp_selmux_rr;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [127:0] IN_DATA;
    logic [3:0]  IN_VALID;
    logic [3:0]  IN_READY;
    logic [1:0]  MODE;
    logic [1:0]  SEL;
    logic [31:0] Y;
    logic [1:0]  Y_CH;
    logic        Y_VALID;
    logic        Y_READY;

    logic [23:0] in_data_b;
    logic [2:0]  in_valid_b;
    logic [2:0]  in_ready_b;
    logic [1:0]  mode_b;
    logic [1:0]  sel_b;
    logic [7:0]  y_b;
    logic [1:0]  y_ch_b;
    logic        y_valid_b;
    logic        y_ready_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dp_selmux_rr #(.N(32), .CH(4), .SW(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .MODE(MODE), .SEL(SEL), .Y(Y), .Y_CH(Y_CH),
        .Y_VALID(Y_VALID), .Y_READY(Y_READY)
    );

    dp_selmux_rr #(.N(8), .CH(3), .SW(2)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .IN_DATA(in_data_b), .IN_VALID(in_valid_b),
        .IN_READY(in_ready_b), .MODE(mode_b), .SEL(sel_b), .Y(y_b), .Y_CH(y_ch_b),
        .Y_VALID(y_valid_b), .Y_READY(y_ready_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit past the next rising edge; inputs change there.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_y(input string tag, input logic [31:0] y_e, input logic [1:0] ch_e, input logic v_e);
        chk({tag, ".y"}, 64'(Y), 64'(y_e));
        chk({tag, ".ych"}, 64'(Y_CH), 64'(ch_e));
        chk({tag, ".yvalid"}, 64'(Y_VALID), 64'(v_e));
    endtask

    initial begin
        IN_DATA    = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        in_data_b  = {8'hC2, 8'hC1, 8'hC0};
        in_valid_b = 3'b000;
        mode_b     = 2'b00;
        sel_b      = 2'd0;
        y_ready_b  = 1'b1;

        // Reset with every channel offering
        RST_N = 1'b0; IN_VALID = 4'b1111; MODE = 2'b01; SEL = 2'd0; Y_READY = 1'b1;
        tick(); tick();
        chk_y("reset", 32'h0, 2'd0, 1'b0);
        chk("reset.inready", 64'(IN_READY), 64'h0);
        RST_N = 1'b1;
        #1;
        chk("rel.inready", 64'(IN_READY), 64'b0001);
        tick();
        chk_y("rel", 32'hA000_0000, 2'd0, 1'b1);

        // Forced select
        MODE = 2'b00; SEL = 2'd2;
        #1 chk("forced.inready", 64'(IN_READY), 64'b0100);
        tick();
        chk_y("forced", 32'hA000_0002, 2'd2, 1'b1);
        SEL = 2'd3; IN_VALID = 4'b0111;
        #1 chk("forced_inv.inready", 64'(IN_READY), 64'h0);
        tick();
        chk_y("forced_inv", 32'hA000_0002, 2'd2, 1'b0);

        // Fixed priority starves channel 3
        MODE = 2'b01; IN_VALID = 4'b1010;
        #1 chk("prio.inready", 64'(IN_READY), 64'b0010);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_y("prio", 32'hA000_0001, 2'd1, 1'b1);
        end

        // Round robin from ptr 0 with all valid
        MODE = 2'b10; IN_VALID = 4'b1111;
        #1 chk("rr.inready", 64'(IN_READY), 64'b0001);
        tick(); chk_y("rr0", 32'hA000_0000, 2'd0, 1'b1);
        tick(); chk_y("rr1", 32'hA000_0001, 2'd1, 1'b1);
        tick(); chk_y("rr2", 32'hA000_0002, 2'd2, 1'b1);
        tick(); chk_y("rr3", 32'hA000_0003, 2'd3, 1'b1);
        tick(); chk_y("rr4", 32'hA000_0000, 2'd0, 1'b1);
        tick(); chk_y("rr5", 32'hA000_0001, 2'd1, 1'b1);

        // ptr is 2; only channel 0 valid wraps the search
        IN_VALID = 4'b0001;
        #1 chk("rrwrap.inready", 64'(IN_READY), 64'b0001);
        tick(); chk_y("rrwrap", 32'hA000_0000, 2'd0, 1'b1);
        IN_VALID = 4'b1111;
        #1 chk("rrptr1.inready", 64'(IN_READY), 64'b0010);
        tick(); chk_y("rrptr1", 32'hA000_0001, 2'd1, 1'b1);

        // Backpressure: held word frozen while inputs/mode/select toggle
        Y_READY = 1'b0; MODE = 2'b00; SEL = 2'd0; IN_VALID = 4'b1111;
        #1 chk("bp0.inready", 64'(IN_READY), 64'h0);
        tick(); chk_y("bp0", 32'hA000_0001, 2'd1, 1'b1);
        SEL = 2'd3; IN_VALID = 4'b0101;
        #1 chk("bp1.inready", 64'(IN_READY), 64'h0);
        tick(); chk_y("bp1", 32'hA000_0001, 2'd1, 1'b1);
        MODE = 2'b01; IN_VALID = 4'b1000;
        #1 chk("bp2.inready", 64'(IN_READY), 64'h0);
        tick(); chk_y("bp2", 32'hA000_0001, 2'd1, 1'b1);
        // Drain and reload on one edge; ptr still 2
        Y_READY = 1'b1; MODE = 2'b10; IN_VALID = 4'b1111;
        #1 chk("drain.inready", 64'(IN_READY), 64'b0100);
        tick(); chk_y("drain", 32'hA000_0002, 2'd2, 1'b1);

        // Reset mid-hold discards the word and returns ptr to 0 (it was 3)
        Y_READY = 1'b0;
        #1 RST_N = 1'b0;
        #1 chk_y("midrst", 32'h0, 2'd0, 1'b0);
        chk("midrst.inready", 64'(IN_READY), 64'h0);
        tick();
        RST_N = 1'b1; Y_READY = 1'b1;
        #1 chk("postrst.inready", 64'(IN_READY), 64'b0001);
        tick(); chk_y("postrst", 32'hA000_0000, 2'd0, 1'b1);

        // 3-channel instance: out-of-range forced select grants nothing
        in_valid_b = 3'b111; mode_b = 2'b00; sel_b = 2'd3;
        #1 chk("b_sel3.inready", 64'(in_ready_b), 64'b000);
        tick(); chk("b_sel3.yvalid", 64'(y_valid_b), 64'h0);
        // Accept channel 2 in round robin, ptr wraps to 0
        mode_b = 2'b10; in_valid_b = 3'b100;
        #1 chk("b_ch2.inready", 64'(in_ready_b), 64'b100);
        tick();
        chk("b_ch2.ych", 64'(y_ch_b), 64'd2);
        chk("b_ch2.y", 64'(y_b), 64'hC2);
        in_valid_b = 3'b111;
        #1 chk("b_wrap.inready", 64'(in_ready_b), 64'b001);
        tick();
        chk("b_wrap.ych", 64'(y_ch_b), 64'd0);
        chk("b_wrap.y", 64'(y_b), 64'hC0);
        chk("b_wrap.yvalid", 64'(y_valid_b), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
